lcd1602_writer: RTL and testbench

Consumer side of the UART receive FIFO. Pops received bytes and drives an HD44780/LCD1602 in 8-bit write-only mode, replacing the tied-off rs/rw/enable/data_lcd outputs of the UART top.
Runs power-up initialisation, then writes printable bytes with cursor tracking, line wrap and CR/LF/FF handling.

---
 rtl/lcd1602_writer.sv | 122 ++++++++++++
 tb/tb_lcd1602_writer.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/lcd1602_writer.sv
// UART RX FIFO consumer driving an HD44780/LCD1602 in 8-bit write-only mode.
// Optional LCD_FILTER_EN: drop non-printable bytes other than LF/FF/CR.
`timescale 1ns/1ps
module lcd1602_writer #(
  parameter int T_POWERUP = 1000000,
  parameter int T_SU      = 2,
  parameter int T_EN      = 25,
  parameter int T_EXEC    = 2500,
  parameter int T_CLEAR   = 100000,
  parameter int CNT_BITS  = 20
) (
  input  logic       clk_50MHz,
  input  logic       reset,
  input  logic       fifo_empty,
  input  logic [7:0] fifo_data,
  output logic       fifo_rd_en,
  output logic       rs,
  output logic       rw,
  output logic       enable,
  output logic [7:0] data_lcd,
  output logic       init_done,
  output logic       busy
);
  typedef enum logic [2:0] {PWR_WAIT, INIT, IDLE, CAPTURE, DECODE, SETUP, EN_HI, EXEC} state_t;

  localparam logic [CNT_BITS-1:0] C_PWR = CNT_BITS'(T_POWERUP - 1);
  localparam logic [CNT_BITS-1:0] C_SU  = CNT_BITS'(T_SU - 1);
  localparam logic [CNT_BITS-1:0] C_EN  = CNT_BITS'(T_EN - 1);
  localparam logic [CNT_BITS-1:0] C_EX  = CNT_BITS'(T_EXEC - 1);
  localparam logic [CNT_BITS-1:0] C_CLR = CNT_BITS'(T_CLEAR - 1);
  localparam logic [CNT_BITS-1:0] ONE   = CNT_BITS'(1);

  state_t              state, state_n;
  logic [CNT_BITS-1:0] cnt, cnt_n, exec_last;
  logic [1:0]          idx, idx_n;
  logic [7:0]          chr, chr_n, dat_n;
  logic [4:0]          col, col_n, pcol, pcol_n;
  logic                line, line_n, pline, pline_n, wrap, wrap_n;
  logic                rs_n, en_n, rd_n, done_n, drop;

  assign rw = 1'b0;
  assign exec_last = (!rs && data_lcd == 8'h01) ? C_CLR : C_EX;

`ifdef LCD_FILTER_EN
  assign drop = !(chr inside {8'h0A, 8'h0C, 8'h0D}) && (chr < 8'h20 || chr > 8'h7E);
`else
  assign drop = 1'b0;
`endif

  function automatic logic [7:0] init_cmd(input logic [1:0] i);
    case (i)
      2'd0:    return 8'h38;
      2'd1:    return 8'h0C;
      2'd2:    return 8'h01;
      default: return 8'h06;
    endcase
  endfunction

  always_comb begin
    state_n = state; cnt_n = cnt; idx_n = idx; chr_n = chr;
    col_n = col; line_n = line; pcol_n = pcol; pline_n = pline; wrap_n = wrap;
    rs_n = rs; dat_n = data_lcd; en_n = enable; rd_n = 1'b0; done_n = init_done;
    case (state)
      PWR_WAIT: if (cnt == C_PWR) begin state_n = INIT; cnt_n = '0; idx_n = 2'd0; end
                else cnt_n = cnt + ONE;
      INIT: begin
        rs_n = 1'b0; dat_n = init_cmd(idx); cnt_n = '0; wrap_n = 1'b0;
        pcol_n = col; pline_n = line; state_n = SETUP;
      end
      IDLE: if (!fifo_empty) begin rd_n = 1'b1; cnt_n = '0; state_n = CAPTURE; end
      // rd_en is registered, so the pop lands at the end of the first CAPTURE
      // cycle and the byte is only valid on the second.
      CAPTURE: if (cnt == '0) cnt_n = ONE;
               else begin chr_n = fifo_data; state_n = DECODE; end
      DECODE: begin
        cnt_n = '0; wrap_n = 1'b0; state_n = SETUP; rs_n = 1'b0; pcol_n = 5'd0;
        if (drop) state_n = IDLE;
        else case (chr)
          8'h0D: begin dat_n = {1'b1, line, 6'b0};  pline_n = line;  end
          8'h0A: begin dat_n = {1'b1, ~line, 6'b0}; pline_n = ~line; end
          8'h0C: begin dat_n = 8'h01;               pline_n = 1'b0;  end
          default:
            if (col == 5'd16) begin
              dat_n = {1'b1, ~line, 6'b0}; pline_n = ~line; wrap_n = 1'b1;
            end else begin
              rs_n = 1'b1; dat_n = chr; pcol_n = col + 5'd1; pline_n = line;
            end
        endcase
      end
      SETUP: if (cnt == C_SU) begin en_n = 1'b1; cnt_n = '0; state_n = EN_HI; end
             else cnt_n = cnt + ONE;
      EN_HI: if (cnt == C_EN) begin en_n = 1'b0; cnt_n = '0; state_n = EXEC; end
             else cnt_n = cnt + ONE;
      EXEC:
        if (cnt == exec_last) begin
          cnt_n = '0; col_n = pcol; line_n = pline;
          if (wrap) begin
            // cursor already moved to the new line; now the deferred char
            wrap_n = 1'b0; rs_n = 1'b1; dat_n = chr; pcol_n = 5'd1; state_n = SETUP;
          end else if (!init_done) begin
            if (idx == 2'd3) begin done_n = 1'b1; state_n = IDLE; end
            else begin idx_n = idx + 2'd1; state_n = INIT; end
          end else state_n = IDLE;
        end else cnt_n = cnt + ONE;
      default: state_n = PWR_WAIT;
    endcase
  end

  always_ff @(posedge clk_50MHz or negedge reset) begin
    if (!reset) begin
      state <= PWR_WAIT; cnt <= '0; idx <= 2'd0; chr <= 8'h00;
      col <= 5'd0; line <= 1'b0; pcol <= 5'd0; pline <= 1'b0; wrap <= 1'b0;
      rs <= 1'b0; data_lcd <= 8'h00; enable <= 1'b0; fifo_rd_en <= 1'b0;
      init_done <= 1'b0; busy <= 1'b1;
    end else begin
      state <= state_n; cnt <= cnt_n; idx <= idx_n; chr <= chr_n;
      col <= col_n; line <= line_n; pcol <= pcol_n; pline <= pline_n; wrap <= wrap_n;
      rs <= rs_n; data_lcd <= dat_n; enable <= en_n; fifo_rd_en <= rd_n;
      init_done <= done_n; busy <= (state_n != IDLE);
    end
  end
endmodule

// File: tb/tb_lcd1602_writer.sv
// Directed bench for lcd1602_writer: FIFO model, LCD bus monitor, immediate-assert checks.
`timescale 1ns/1ps
module tb_lcd1602_writer;
  localparam int TPU = 100, TSU = 2, TEN = 12, TEX = 20, TCL = 60;

  logic       clk = 1'b0;
  logic       reset;
  logic       fifo_empty, fifo_rd_en, rs, rw, enable, init_done, busy;
  logic [7:0] fifo_data = 8'h00;
  logic [7:0] data_lcd;

  lcd1602_writer #(.T_POWERUP(TPU), .T_SU(TSU), .T_EN(TEN), .T_EXEC(TEX), .T_CLEAR(TCL),
                   .CNT_BITS(20)) dut (
    .clk_50MHz(clk), .reset(reset), .fifo_empty(fifo_empty), .fifo_data(fifo_data),
    .fifo_rd_en(fifo_rd_en), .rs(rs), .rw(rw), .enable(enable), .data_lcd(data_lcd),
    .init_done(init_done), .busy(busy));

  always #10 clk = ~clk;

  // FIFO model: registered dout, valid the cycle after the pop strobe
  logic [7:0] fmem [256];
  int wp = 0, rp = 0;
  assign fifo_empty = (wp == rp);
  always @(posedge clk)
    if (fifo_rd_en && rp != wp) begin fifo_data <= fmem[rp]; rp <= rp + 1; end

  // LCD bus monitor
  logic       ev_rs  [128];
  logic [7:0] ev_dat [128];
  int ev_hi [128], ev_gap [128], ev_cyc [128];
  int ev_n = 0, cyc = 0, hi = 0, low = 0, pops = 0, rd_bad = 0;
  int fall_cyc = 0, done_cyc = 0, bfall_cyc = 0;
  logic en_q = 1'b0, busy_q = 1'b0, done_q = 1'b0;
  always @(negedge clk) begin
    cyc <= cyc + 1; en_q <= enable; busy_q <= busy; done_q <= init_done;
    if (enable && !en_q) begin
      ev_rs[ev_n] <= rs; ev_dat[ev_n] <= data_lcd; ev_gap[ev_n] <= low;
      ev_cyc[ev_n] <= cyc; ev_n <= ev_n + 1; hi <= 1;
    end else if (enable) hi <= hi + 1;
    if (!enable && en_q) begin ev_hi[ev_n-1] <= hi; fall_cyc <= cyc; low <= 1; end
    else if (!enable) low <= low + 1;
    if (fifo_rd_en) begin pops <= pops + 1; if (!init_done) rd_bad <= rd_bad + 1; end
    if (init_done && !done_q) done_cyc <= cyc;
    if (!busy && busy_q) bfall_cyc <= cyc;
  end

  int checks = 0, errors = 0;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic push(input logic [7:0] b);
    fmem[wp] = b; wp = wp + 1;
  endtask

  task automatic wait_idle(input string tag);
    int st = 0, n = 0;
    while (st < 3 && n < 5000) begin
      @(negedge clk); n++;
      if (!busy && wp == rp) st++; else st = 0;
    end
    chk(tag, 32'(st >= 3), 1);
  endtask

  task automatic wait_done(input string tag);
    int n = 0;
    while (!init_done && n < 3000) begin @(negedge clk); n++; end
    chk(tag, 32'(init_done), 1);
    repeat (2) @(negedge clk);
  endtask

  task automatic chk_init_seq(input string tag, input int e0, input int rel);
    logic [7:0] exp_cmd [4];
    exp_cmd[0] = 8'h38; exp_cmd[1] = 8'h0C; exp_cmd[2] = 8'h01; exp_cmd[3] = 8'h06;
    chk({tag, "_npulses"}, ev_n - e0, 4);
    chk({tag, "_pwr_quiet"}, 32'(ev_cyc[e0] - rel >= TPU), 1);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("%s_cmd%0d", tag, i), {23'd0, ev_rs[e0+i], ev_dat[e0+i]}, {24'd0, exp_cmd[i]});
      chk($sformatf("%s_hi%0d", tag, i), ev_hi[e0+i], TEN);
    end
    chk({tag, "_gap_norm"}, 32'(ev_gap[e0+2] < TCL), 1);
    chk({tag, "_gap_clear"}, 32'(ev_gap[e0+3] >= TCL && ev_gap[e0+3] < TCL + 40), 1);
    chk({tag, "_done_after_exec"}, 32'(done_cyc - fall_cyc >= TEX), 1);
  endtask

  initial begin
    int e0, p0, rel, n;
    reset = 1'b1;
    #5 reset = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_outputs", {rs, rw, enable, fifo_rd_en, init_done, busy}, 6'b000001);
    chk("rst_data", data_lcd, 8'h00);

    // 1: power-up wait and init sequence, no pops
    e0 = ev_n; rel = cyc;
    reset = 1'b1;
    wait_done("t1_done");
    chk_init_seq("t1", e0, rel);
    chk("t1_no_pops", pops, 0);
    chk("t1_rw", rw, 0);

    // 2: single char
    e0 = ev_n; p0 = pops;
    push(8'h41);
    wait_idle("t2_idle");
    chk("t2_pops", pops - p0, 1);
    chk("t2_npulses", ev_n - e0, 1);
    chk("t2_char", {ev_rs[e0], ev_dat[e0]}, 9'h141);
    chk("t2_hi", ev_hi[e0], TEN);
    chk("t2_busy_after_exec", 32'(bfall_cyc - fall_cyc >= TEX), 1);

    // CR to bring the cursor back to col 0, line 0
    e0 = ev_n; push(8'h0D); wait_idle("cr_idle");
    chk("cr_cmd", {ev_rs[e0], ev_dat[e0]}, 9'h080);

    // 3: 17 chars -> wrap to line 1 before the 17th
    e0 = ev_n; p0 = pops;
    for (int i = 0; i < 17; i++) push(8'h30 + 8'(i));
    wait_idle("t3_idle");
    chk("t3_pops", pops - p0, 17);
    chk("t3_npulses", ev_n - e0, 18);
    for (int i = 0; i < 16; i++)
      chk($sformatf("t3_char%0d", i), {ev_rs[e0+i], ev_dat[e0+i]}, {1'b1, 8'h30 + 8'(i)});
    chk("t3_wrap_cmd", {ev_rs[e0+16], ev_dat[e0+16]}, 9'h0C0);
    chk("t3_after_wrap", {ev_rs[e0+17], ev_dat[e0+17]}, 9'h140);

    // LF from line 1 returns to line 0
    e0 = ev_n; push(8'h0A); wait_idle("lf0_idle");
    chk("lf0_cmd", {ev_rs[e0], ev_dat[e0]}, 9'h080);

    // 4: LF then CR from line 0
    e0 = ev_n; push(8'h0A); push(8'h0D); wait_idle("t4_idle");
    chk("t4_npulses", ev_n - e0, 2);
    chk("t4_lf", {ev_rs[e0], ev_dat[e0]}, 9'h0C0);
    chk("t4_cr", {ev_rs[e0+1], ev_dat[e0+1]}, 9'h0C0);

    // 5: form feed then char
    e0 = ev_n; push(8'h0C); push(8'h42); wait_idle("t5_idle");
    chk("t5_npulses", ev_n - e0, 2);
    chk("t5_clear", {ev_rs[e0], ev_dat[e0]}, 9'h001);
    chk("t5_char", {ev_rs[e0+1], ev_dat[e0+1]}, 9'h142);
    chk("t5_clear_gap", 32'(ev_gap[e0+1] >= TCL && ev_gap[e0+1] < TCL + 40), 1);

    // non-printable byte
    e0 = ev_n; p0 = pops; push(8'h07); wait_idle("np_idle");
    chk("np_pops", pops - p0, 1);
`ifdef LCD_FILTER_EN
    chk("np_dropped", ev_n - e0, 0);
`else
    chk("np_npulses", ev_n - e0, 1);
    chk("np_raw", {ev_rs[e0], ev_dat[e0]}, 9'h107);
`endif

    // 6: reset during EN_HI of a char write
    push(8'h43);
    n = 0;
    while (!enable && n < 300) begin @(negedge clk); n++; end
    chk("t6_en_seen", enable, 1);
    @(negedge clk);
    #3 reset = 1'b0;
    #1 chk("t6_en_async", enable, 0);
    chk("t6_rst_state", {busy, init_done, rs, fifo_rd_en}, 4'b1000);
    repeat (3) @(negedge clk);
    chk("t6_interrupted", {ev_rs[ev_n-1], ev_dat[ev_n-1]}, 9'h143);
    e0 = ev_n; p0 = pops; rel = cyc;
    reset = 1'b1;
    wait_done("t6_done");
    chk_init_seq("t6", e0, rel);
    chk("t6_no_pops", pops - p0, 0);
    chk("rd_before_init", rd_bad, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
